// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU control path: opcodes, FSM states,
// instruction field positions and small decode helpers.
package cpu_pkg;

   localparam int INSTR_W = 10;

   // Instruction field bit positions
   localparam int OP_MSB  = 9;
   localparam int OP_LSB  = 6;
   localparam int F1_MSB  = 5;   // dd / rr
   localparam int F1_LSB  = 4;
   localparam int F2_MSB  = 3;   // rr / ss / qq
   localparam int F2_LSB  = 2;
   localparam int F3_MSB  = 1;   // qq
   localparam int F3_LSB  = 0;
   localparam int IMM_MSB = 3;
   localparam int TGT_MSB = 5;

   typedef enum logic [3:0] {
      OP_NOT  = 4'b0000,
      OP_LT   = 4'b0001,
      OP_INC  = 4'b0010,
      OP_DEC  = 4'b0011,
      OP_ADD  = 4'b0100,
      OP_SUB  = 4'b0101,
      OP_AND  = 4'b0110,
      OP_OR   = 4'b0111,
      OP_MOV  = 4'b1000,
      OP_LDI  = 4'b1001,
      OP_JMP  = 4'b1010,
      OP_BRZ  = 4'b1011,
      OP_BRNZ = 4'b1100,
      OP_NOP  = 4'b1101,
      OP_RSVD = 4'b1110,
      OP_HALT = 4'b1111
   } opcode_e;

   localparam logic [3:0] ALU_PASS = 4'b1000;

   localparam logic [INSTR_W-1:0] IR_RESET = 10'b1101_000000;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] ir);
      return opcode_e'(ir[OP_MSB:OP_LSB]);
   endfunction

   // Opcodes 0000..1000 drive the ALU and therefore refresh the Z flag.
   function automatic logic uses_alu(input opcode_e op);
      return (op <= OP_MOV);
   endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch bus between the control unit (master) and the
// instruction memory (slave).
interface cpu_control_unit_if #(
   parameter int PC_W = 6
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [9:0]      imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/cpu_instr_decode.sv
// Purely combinational instruction decode: IR to ALU select, register-file
// addresses, writeback source and instruction-class flags.
module cpu_instr_decode
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output logic [3:0]         alu_cntrl,
   output logic [3:0]         imm_num,
   output logic [1:0]         rf_raddr_a,
   output logic [1:0]         rf_raddr_b,
   output logic [1:0]         rf_waddr,
   output logic               wb_sel,
   output logic               writes_rf,
   output logic               updates_z,
   output logic               is_branch,
   output logic               is_halt
);

   opcode_e op;

   assign op       = get_opcode(ir);
   assign imm_num  = ir[IMM_MSB:0];
   assign rf_waddr = ir[F1_MSB:F1_LSB];

   // NOTE: every output gets a default before the case so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      alu_cntrl  = ALU_PASS;
      rf_raddr_a = ir[F2_MSB:F2_LSB];
      rf_raddr_b = ir[F3_MSB:F3_LSB];
      wb_sel     = 1'b0;
      writes_rf  = 1'b0;
      updates_z  = uses_alu(op);
      is_branch  = 1'b0;
      is_halt    = 1'b0;

      if (uses_alu(op)) begin
         alu_cntrl = ir[OP_MSB:OP_LSB];
      end

      unique case (op)
         OP_LT: begin
            rf_raddr_a = ir[F1_MSB:F1_LSB];
            rf_raddr_b = ir[F2_MSB:F2_LSB];
         end
         OP_INC, OP_DEC: begin
            rf_raddr_a = ir[F1_MSB:F1_LSB];
            writes_rf  = 1'b1;
         end
         OP_NOT, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: begin
            writes_rf = 1'b1;
         end
         OP_LDI: begin
            wb_sel    = 1'b1;
            writes_rf = 1'b1;
         end
         OP_JMP, OP_BRZ, OP_BRNZ: begin
            is_branch = 1'b1;
         end
         OP_HALT: begin
            is_halt = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 10-bit CPU.
// Owns PC, instruction register and the latched Z flag.
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 6,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   cpu_control_unit_if.master  imem,
   output logic [3:0]          alu_cntrl,
   output logic [3:0]          imm_num,
   output logic [1:0]          rf_raddr_a,
   output logic [1:0]          rf_raddr_b,
   output logic [1:0]          rf_waddr,
   output logic                rf_we,
   output logic                wb_sel,
   input  logic                alu_z,
   output logic                z_flag,
   output logic [PC_W-1:0]     pc,
   output logic                halted
);

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q;
   logic [INSTR_W-1:0]   ir_q;
   logic                 z_q;

   logic                 fetch_req;
   logic                 fetch_fire;
   logic                 take_branch;
   logic [PC_W-1:0]      branch_tgt;
   opcode_e              op;

   logic                 writes_rf;
   logic                 updates_z;
   logic                 is_branch;
   logic                 is_halt;

   cpu_instr_decode u_decode (
      .ir         (ir_q),
      .alu_cntrl  (alu_cntrl),
      .imm_num    (imm_num),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_waddr   (rf_waddr),
      .wb_sel     (wb_sel),
      .writes_rf  (writes_rf),
      .updates_z  (updates_z),
      .is_branch  (is_branch),
      .is_halt    (is_halt)
   );

   assign op         = get_opcode(ir_q);
   assign branch_tgt = PC_W'(ir_q[TGT_MSB:0]);
   assign fetch_fire = fetch_req && imem.imem_ack;

   // Branches look at z_q before any update in this EXECUTE cycle.
   always_comb begin
      take_branch = 1'b0;
      if (is_branch) begin
         unique case (op)
            OP_JMP:  take_branch = 1'b1;
            OP_BRZ:  take_branch = z_q;
            OP_BRNZ: take_branch = !z_q;
            default: take_branch = 1'b0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fetch_req = 1'b0;
      rf_we     = 1'b0;
      halted    = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            fetch_req = run && !rst;
            if (fetch_fire) state_d = ST_DECODE;
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            if (writes_rf)    state_d = ST_WB;
            else if (is_halt) state_d = ST_HALT;
            else              state_d = ST_FETCH;
         end
         ST_WB: begin
            rf_we   = !rst;
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            halted = !rst;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
         ir_q <= IR_RESET;
         z_q  <= 1'b0;
      end else begin
         if (fetch_fire) begin
            ir_q <= imem.imem_rdata;
            pc_q <= pc_q + PC_W'(1);
         end
         if (state_q == ST_EXEC) begin
            if (updates_z)   z_q  <= alu_z;
            if (take_branch) pc_q <= branch_tgt;
         end
      end
   end

   assign imem.imem_req  = fetch_req;
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign z_flag         = z_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed, table-driven bench for cpu_control_unit with a hand-driven
// instruction-memory responder and ALU zero flag.
module tb_cpu_control_unit;
   import cpu_pkg::*;

   localparam int PC_W = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            run;
   logic [3:0]      alu_cntrl;
   logic [3:0]      imm_num;
   logic [1:0]      rf_raddr_a;
   logic [1:0]      rf_raddr_b;
   logic [1:0]      rf_waddr;
   logic            rf_we;
   logic            wb_sel;
   logic            alu_z;
   logic            z_flag;
   logic [PC_W-1:0] pc;
   logic            halted;

   int n_cmp = 0;
   int n_bad = 0;
   logic [PC_W-1:0] exp_pc;

   cpu_control_unit_if #(.PC_W(PC_W)) bus ();

   cpu_control_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .imem       (bus.master),
      .alu_cntrl  (alu_cntrl),
      .imm_num    (imm_num),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_waddr   (rf_waddr),
      .rf_we      (rf_we),
      .wb_sel     (wb_sel),
      .alu_z      (alu_z),
      .z_flag     (z_flag),
      .pc         (pc),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] instr;
      logic       alu_z;
      logic [3:0] alu;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [1:0] wa;
      logic       wb_sel;
      logic       we;
      int         cycles;
      logic [5:0] pc_after;
      logic       z_after;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Entered at a negedge with the DUT in FETCH; leaves at a negedge with the
   // DUT back in FETCH (or after the cycle budget expires).
   task automatic exec_one(input vec_t v, input int delay);
      int cyc;
      int we_cnt;
      alu_z = v.alu_z;
      bus.imem_ack = 1'b0;
      for (int i = 0; i < delay; i++) begin
         #1;
         check("wait_req",  32'(bus.imem_req),  32'(1));
         check("wait_addr", 32'(bus.imem_addr), 32'(exp_pc));
         check("wait_pc",   32'(pc),            32'(exp_pc));
         check("wait_ir",   32'(alu_cntrl),     32'(ALU_PASS));
         @(negedge clk);
      end
      check("fetch_req",  32'(bus.imem_req),  32'(1));
      check("fetch_addr", 32'(bus.imem_addr), 32'(exp_pc));
      bus.imem_rdata = v.instr;
      bus.imem_ack   = 1'b1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      check("alu_cntrl",  32'(alu_cntrl),  32'(v.alu));
      check("imm_num",    32'(imm_num),    32'(v.instr[3:0]));
      check("rf_raddr_a", 32'(rf_raddr_a), 32'(v.ra));
      check("rf_raddr_b", 32'(rf_raddr_b), 32'(v.rb));
      check("rf_waddr",   32'(rf_waddr),   32'(v.wa));
      check("wb_sel",     32'(wb_sel),     32'(v.wb_sel));
      cyc = 1;
      we_cnt = 0;
      while (!bus.imem_req && cyc < 8) begin
         if (rf_we) begin
            we_cnt++;
            check("we_cycle", 32'(cyc),      32'(3));
            check("we_waddr", 32'(rf_waddr), 32'(v.wa));
            check("we_wbsel", 32'(wb_sel),   32'(v.wb_sel));
         end
         @(negedge clk);
         #1;
         cyc++;
      end
      check("return_to_fetch", 32'(bus.imem_req), 32'(1));
      check("cycles",   32'(cyc),    32'(v.cycles));
      check("we_count", 32'(we_cnt), 32'(v.we));
      check("pc_after", 32'(pc),     32'(v.pc_after));
      check("z_after",  32'(z_flag), 32'(v.z_after));
      exp_pc = v.pc_after;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_req",    32'(bus.imem_req), 32'(0));
      check("rst_we",     32'(rf_we),        32'(0));
      check("rst_halted", 32'(halted),       32'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_pc",     32'(pc),            32'(0));
      check("rst_z",      32'(z_flag),        32'(0));
      check("rst_ir",     32'(alu_cntrl),     32'(ALU_PASS));
      check("rst_fetch",  32'(bus.imem_req),  32'(1));
      check("rst_addr",   32'(bus.imem_addr), 32'(0));
      exp_pc = '0;
   endtask

   initial begin
      vec_t lt_v;
      vec_t add_v;
      vec_t add_d;
      rst = 1'b1;
      run = 1'b1;
      alu_z = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      exp_pc = '0;

      //            instr              z  alu      ra rb wa wb we cyc pc  z
      vecs[0]  = '{10'b0100_01_10_11, 0, 4'b0100, 2, 3, 1, 0, 1, 4,  1, 0}; // ADD
      vecs[1]  = '{10'b1001_10_1001,  1, 4'b1000, 2, 1, 2, 1, 1, 4,  2, 0}; // LDI
      vecs[2]  = '{10'b0001_01_11_00, 1, 4'b0001, 1, 3, 1, 0, 0, 3,  3, 1}; // LT
      vecs[3]  = '{10'b1011_010100,   0, 4'b1000, 1, 0, 1, 0, 0, 3, 20, 1}; // BRZ taken
      vecs[4]  = '{10'b1100_101000,   0, 4'b1000, 2, 0, 2, 0, 0, 3, 21, 1}; // BRNZ not
      vecs[5]  = '{10'b0101_00_01_10, 0, 4'b0101, 1, 2, 0, 0, 1, 4, 22, 0}; // SUB
      vecs[6]  = '{10'b1011_000101,   0, 4'b1000, 1, 1, 0, 0, 0, 3, 23, 0}; // BRZ not
      vecs[7]  = '{10'b1100_101000,   0, 4'b1000, 2, 0, 2, 0, 0, 3, 40, 0}; // BRNZ taken
      vecs[8]  = '{10'b0010_11_0010,  1, 4'b0010, 3, 2, 3, 0, 1, 4, 41, 1}; // INC
      vecs[9]  = '{10'b0011_10_0001,  0, 4'b0011, 2, 1, 2, 0, 1, 4, 42, 0}; // DEC
      vecs[10] = '{10'b0000_01_10_00, 1, 4'b0000, 2, 0, 1, 0, 1, 4, 43, 1}; // NOT
      vecs[11] = '{10'b0110_11_00_01, 0, 4'b0110, 0, 1, 3, 0, 1, 4, 44, 0}; // AND
      vecs[12] = '{10'b0111_10_11_11, 1, 4'b0111, 3, 3, 2, 0, 1, 4, 45, 1}; // OR
      vecs[13] = '{10'b1000_00_11_00, 0, 4'b1000, 3, 0, 0, 0, 1, 4, 46, 0}; // MOV
      vecs[14] = '{10'b1101_000000,   1, 4'b1000, 0, 0, 0, 0, 0, 3, 47, 0}; // NOP
      vecs[15] = '{10'b1110_000000,   1, 4'b1000, 0, 0, 0, 0, 0, 3, 48, 0}; // reserved
      vecs[16] = '{10'b1010_111110,   0, 4'b1000, 3, 2, 3, 0, 0, 3, 62, 0}; // JMP 62
      vecs[17] = '{10'b1101_000000,   0, 4'b1000, 0, 0, 0, 0, 0, 3, 63, 0}; // NOP
      vecs[18] = '{10'b1101_000000,   0, 4'b1000, 0, 0, 0, 0, 0, 3,  0, 0}; // wrap
      vecs[19] = '{10'b1010_111111,   0, 4'b1000, 3, 3, 3, 0, 0, 3, 63, 0}; // JMP 63
      vecs[20] = '{10'b1101_000000,   0, 4'b1000, 0, 0, 0, 0, 0, 3,  0, 0}; // wrap

      do_reset();
      for (int i = 0; i < 21; i++) begin
         exec_one(vecs[i], 0);
      end

      // Fetch ack held off three cycles; previous IR was a NOP.
      add_d = '{10'b0100_01_10_11, 0, 4'b0100, 2, 3, 1, 0, 1, 4, 1, 0};
      exec_one(add_d, 3);
      lt_v  = '{10'b0001_01_11_00, 1, 4'b0001, 1, 3, 1, 0, 0, 3, 2, 1};
      exec_one(lt_v, 0);

      // Reset while a write op sits in EXECUTE.
      add_v = '{10'b0100_01_10_11, 0, 4'b0100, 2, 3, 1, 0, 1, 4, 3, 0};
      bus.imem_rdata = add_v.instr;
      bus.imem_ack   = 1'b1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midexec_we", 32'(rf_we), 32'(0));
      @(negedge clk);
      #1;
      check("midexec_we2", 32'(rf_we),        32'(0));
      check("midexec_pc",  32'(pc),           32'(0));
      check("midexec_z",   32'(z_flag),       32'(0));
      check("midexec_req", 32'(bus.imem_req), 32'(0));
      rst = 1'b0;
      #1;
      check("midexec_fetch", 32'(bus.imem_req),  32'(1));
      check("midexec_addr",  32'(bus.imem_addr), 32'(0));
      check("midexec_we3",   32'(rf_we),         32'(0));
      exp_pc = '0;

      // HALT: no further fetches until reset.
      bus.imem_rdata = 10'b1111_000000;
      bus.imem_ack   = 1'b1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("halt_flag", 32'(halted), 32'(1));
      check("halt_pc",   32'(pc),     32'(1));
      for (int i = 0; i < 4; i++) begin
         check("halt_req", 32'(bus.imem_req), 32'(0));
         check("halt_we",  32'(rf_we),        32'(0));
         @(negedge clk);
         #1;
      end
      check("halt_hold", 32'(halted), 32'(1));
      do_reset();
      check("halt_clear", 32'(halted), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
